axis_traffic_gen: RTL and testbench

AXIS_TRAFFIC_GEN -- requirements
Module: axis_traffic_gen

---
 rtl/axis_tg_pkg.sv | 19 +
 rtl/axis_traffic_gen.sv | 123 ++++++++++++
 tb/tb_axis_traffic_gen.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_tg_pkg.sv
// Shared definitions for the AXIS traffic generator and its matching sink/checker:
// controller state encoding and the tdata field layout (source ID, sequence, beat index).
package axis_tg_pkg;

    typedef logic [1:0] tg_state_t;

    localparam tg_state_t ST_IDLE = 2'd0;
    localparam tg_state_t ST_SEND = 2'd1;
    localparam tg_state_t ST_GAP  = 2'd2;
    localparam tg_state_t ST_FIN  = 2'd3;

    localparam int unsigned SRC_LSB  = 28;
    localparam int unsigned SRC_W    = 4;
    localparam int unsigned SEQ_LSB  = 12;
    localparam int unsigned SEQ_W    = 16;
    localparam int unsigned BEAT_LSB = 0;
    localparam int unsigned BEAT_W   = 12;

endpackage

// File: rtl/axis_traffic_gen.sv
// AXI-Stream packet generator: a start pulse launches num_pkts packets of pkt_len beats; first beat is
// presented the cycle after start. tvalid is held with stable payload through any tready stall.
module axis_traffic_gen #(
    parameter int unsigned TDEST_WIDTH      = 4,
    parameter int unsigned TDATA_WIDTH      = 32,
    parameter int unsigned SRC_ID           = 0,
    parameter int unsigned NUM_DESTS        = 4,
    parameter int unsigned DISABLE_SELFLOOP = 0,
    parameter int unsigned GAP_CYCLES       = 0
) (
    input  logic                   clk_usr,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [15:0]            num_pkts,
    input  logic [7:0]             pkt_len,
    input  logic                   rr_mode,
    input  logic [TDEST_WIDTH-1:0] fixed_dest,
    output logic                   axis_out_tvalid,
    input  logic                   axis_out_tready,
    output logic [TDATA_WIDTH-1:0] axis_out_tdata,
    output logic                   axis_out_tlast,
    output logic [TDEST_WIDTH-1:0] axis_out_tdest,
    output logic                   busy,
    output logic                   done,
    output logic [15:0]            pkts_sent
);
    import axis_tg_pkg::*;

    tg_state_t              state;
    logic [15:0]            num_r;
    logic [7:0]             len_r;
    logic                   rr_r;
    logic [TDEST_WIDTH-1:0] dest_r;
    logic [SEQ_W-1:0]       seq;
    logic [BEAT_W-1:0]      beat;
    logic [7:0]             gap_cnt;
    logic                   last_beat;

    // Reduce a candidate index into the mesh range, stepping over our own address when self-loops are off.
    function automatic logic [TDEST_WIDTH-1:0] rr_pick(input int unsigned cand);
        int unsigned d;
        d = cand % NUM_DESTS;
        if (DISABLE_SELFLOOP != 0 && d == SRC_ID) begin
            d = (d + 1) % NUM_DESTS;
        end
        return TDEST_WIDTH'(d);
    endfunction

    assign last_beat = (beat == BEAT_W'(len_r - 8'd1));

    always_ff @(posedge clk_usr or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            num_r     <= '0;
            len_r     <= 8'd1;
            rr_r      <= 1'b0;
            dest_r    <= '0;
            seq       <= '0;
            beat      <= '0;
            gap_cnt   <= '0;
            pkts_sent <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        num_r     <= num_pkts;
                        len_r     <= (pkt_len == 8'd0) ? 8'd1 : pkt_len;
                        rr_r      <= rr_mode;
                        dest_r    <= rr_mode ? rr_pick(0) : fixed_dest;
                        seq       <= '0;
                        beat      <= '0;
                        pkts_sent <= '0;
                        state     <= (num_pkts == 16'd0) ? ST_FIN : ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (axis_out_tready) begin
                        if (last_beat) begin
                            beat      <= '0;
                            seq       <= seq + 1'b1;
                            pkts_sent <= pkts_sent + 16'd1;
                            dest_r    <= rr_r ? rr_pick(32'(dest_r) + 1) : dest_r;
                            if (pkts_sent + 16'd1 == num_r) begin
                                state <= ST_FIN;
                            end else if (GAP_CYCLES != 0) begin
                                state   <= ST_GAP;
                                gap_cnt <= 8'(GAP_CYCLES - 1);
                            end
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == 8'd0) begin
                        state <= ST_SEND;
                    end else begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end
                end
                ST_FIN:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign axis_out_tvalid = (state == ST_SEND);
    assign axis_out_tlast  = axis_out_tvalid && last_beat;
    assign axis_out_tdest  = dest_r;
    assign busy            = (state != ST_IDLE);
    assign done            = (state == ST_FIN);

    // Payload is forced to zero whenever no beat is offered so idle/reset shows a clean bus.
    always_comb begin
        axis_out_tdata = '0;
        if (axis_out_tvalid) begin
            axis_out_tdata[SRC_LSB +: SRC_W]   = SRC_W'(SRC_ID);
            axis_out_tdata[SEQ_LSB +: SEQ_W]   = seq;
            axis_out_tdata[BEAT_LSB +: BEAT_W] = beat;
        end
    end

endmodule

// File: tb/tb_axis_traffic_gen.sv
// Drives two generators (self-loop skip with no gap, and 3-cycle gap with self-loops) from one stimulus
// stream; expected beats come from a packet-level model and are checked by a per-DUT monitor.
module tb_axis_traffic_gen;

    localparam int SRC = 2;
    localparam int ND  = 4;
    localparam int DW  = 48;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [3:0]    dest;
        logic          last;
    } beat_t;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                start;
    logic [15:0]         num_pkts;
    logic [7:0]          pkt_len;
    logic                rr_mode;
    logic [3:0]          fixed_dest;
    logic [1:0]          vld, rdy, lst, bsy, dn;
    logic [1:0][DW-1:0]  dat;
    logic [1:0][3:0]     dst;
    logic [1:0][15:0]    sent;

    int    n_cmp = 0;
    int    n_bad = 0;
    int    rmode = 0;
    int    tcyc  = 0;
    beat_t exp_q[2][$];
    int    exp_pkts[2];
    bit    stall[2];
    bit    gap_trk[2];
    bit    done_pend[2];
    int    idle[2];
    beat_t held[2];

    always #5 clk = ~clk;

    axis_traffic_gen #(
        .TDEST_WIDTH(4), .TDATA_WIDTH(DW), .SRC_ID(SRC), .NUM_DESTS(ND),
        .DISABLE_SELFLOOP(1), .GAP_CYCLES(0)
    ) dut_a (
        .clk_usr(clk), .rst_n(rst_n), .start(start), .num_pkts(num_pkts), .pkt_len(pkt_len),
        .rr_mode(rr_mode), .fixed_dest(fixed_dest), .axis_out_tvalid(vld[0]), .axis_out_tready(rdy[0]),
        .axis_out_tdata(dat[0]), .axis_out_tlast(lst[0]), .axis_out_tdest(dst[0]),
        .busy(bsy[0]), .done(dn[0]), .pkts_sent(sent[0])
    );

    axis_traffic_gen #(
        .TDEST_WIDTH(4), .TDATA_WIDTH(DW), .SRC_ID(SRC), .NUM_DESTS(ND),
        .DISABLE_SELFLOOP(0), .GAP_CYCLES(3)
    ) dut_b (
        .clk_usr(clk), .rst_n(rst_n), .start(start), .num_pkts(num_pkts), .pkt_len(pkt_len),
        .rr_mode(rr_mode), .fixed_dest(fixed_dest), .axis_out_tvalid(vld[1]), .axis_out_tready(rdy[1]),
        .axis_out_tdata(dat[1]), .axis_out_tlast(lst[1]), .axis_out_tdest(dst[1]),
        .busy(bsy[1]), .done(dn[1]), .pkts_sent(sent[1])
    );

    function automatic int gap_of(input int i);
        return (i == 0) ? 0 : 3;
    endfunction

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endfunction

    // Packet-level reference: destination list is the mesh minus (optionally) ourselves, cycled per packet.
    function automatic void build(input int i, input int num, input int len, input bit rr, input int fd);
        int    eff;
        int    dest;
        int    cands[$];
        beat_t e;
        eff = (len == 0) ? 1 : len;
        for (int d = 0; d < ND; d++) begin
            if (!(i == 0 && d == SRC)) cands.push_back(d);
        end
        for (int p = 0; p < num; p++) begin
            dest = rr ? cands[p % cands.size()] : fd;
            for (int b = 0; b < eff; b++) begin
                e.data = DW'((longint'(SRC) << 28) | (longint'(p & 16'hffff) << 12) | longint'(b));
                e.dest = 4'(dest);
                e.last = (b == eff - 1);
                exp_q[i].push_back(e);
            end
        end
        exp_pkts[i] = num;
    endfunction

    initial begin
        rdy = 2'b11;
        forever begin
            @(posedge clk);
            #1;
            tcyc++;
            for (int i = 0; i < 2; i++) begin
                case (rmode)
                    0:       rdy[i] = 1'b1;
                    1:       rdy[i] = (tcyc % 4 == 0) || (tcyc % 4 == 3);
                    default: rdy[i] = 1'($urandom_range(0, 1));
                endcase
            end
        end
    end

    always @(negedge clk) begin
        beat_t cur;
        beat_t e;
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                stall[i] = 0; gap_trk[i] = 0; done_pend[i] = 0; idle[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                cur.data = dat[i];
                cur.dest = dst[i];
                cur.last = lst[i];
                if (done_pend[i]) begin
                    chk($sformatf("done_pulse%0d", i), 64'(dn[i]), 64'd1);
                    chk($sformatf("pkts_sent_at_done%0d", i), 64'(sent[i]), 64'(exp_pkts[i]));
                    done_pend[i] = 0;
                end else if (dn[i]) begin
                    chk($sformatf("unexpected_done%0d", i), 64'(dn[i]), 64'd0);
                end
                if (stall[i]) begin
                    chk($sformatf("stall_valid%0d", i), 64'(vld[i]), 64'd1);
                    chk($sformatf("stall_payload%0d", i), 64'(cur), 64'(held[i]));
                end
                if (vld[i]) begin
                    if (gap_trk[i]) begin
                        chk($sformatf("gap_len%0d", i), 64'(idle[i]), 64'(gap_of(i)));
                        gap_trk[i] = 0;
                    end
                    if (rdy[i]) begin
                        stall[i] = 0;
                        if (exp_q[i].size() == 0) begin
                            n_cmp++;
                            n_bad++;
                            $display("FAIL extra_beat%0d: got beat 0x%0h expected no beat", i, cur);
                        end else begin
                            e = exp_q[i].pop_front();
                            chk($sformatf("beat_data%0d", i), 64'(cur.data), 64'(e.data));
                            chk($sformatf("beat_dest%0d", i), 64'(cur.dest), 64'(e.dest));
                            chk($sformatf("beat_last%0d", i), 64'(cur.last), 64'(e.last));
                            if (e.last) begin
                                if (exp_q[i].size() == 0) begin
                                    done_pend[i] = 1;
                                end else begin
                                    gap_trk[i] = 1;
                                    idle[i]    = 0;
                                end
                            end
                        end
                    end else begin
                        stall[i] = 1;
                        held[i]  = cur;
                    end
                end else if (gap_trk[i]) begin
                    idle[i]++;
                end
            end
        end
    end

    task automatic pulse_start(input int num, input int len, input bit rr, input int fd);
        @(posedge clk);
        #1;
        start = 1'b1; num_pkts = 16'(num); pkt_len = 8'(len); rr_mode = rr; fixed_dest = 4'(fd);
        @(posedge clk);
        #1;
        start = 1'b0;
        num_pkts = 16'($urandom); pkt_len = 8'($urandom); rr_mode = 1'($urandom); fixed_dest = 4'($urandom);
    endtask

    task automatic do_run(input int num, input int len, input bit rr, input int fd, input int mode, input bit poke);
        int cyc;
        rmode = mode;
        for (int i = 0; i < 2; i++) build(i, num, len, rr, fd);
        pulse_start(num, len, rr, fd);
        if (num == 0) begin
            for (int i = 0; i < 2; i++) done_pend[i] = 1;
        end
        cyc = 0;
        while (bsy != 2'b00 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (num == 0 && cyc == 1) begin
                chk("zero_pkts_valid", 64'(vld), 64'd0);
            end
            if (poke && cyc == 5 && bsy == 2'b11 && dn == 2'b00) begin
                @(posedge clk);
                #1;
                start = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
            end
        end
        if (cyc >= 5000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL run_timeout: busy=%b still set after %0d cycles, required idle", bsy, cyc);
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("beats_left%0d", i), 64'(exp_q[i].size()), 64'd0);
            chk($sformatf("pkts_sent_final%0d", i), 64'(sent[i]), 64'(num));
            chk($sformatf("idle_valid%0d", i), 64'(vld[i]), 64'd0);
            exp_q[i].delete();
        end
    endtask

    task automatic reset_midpacket();
        int cyc;
        rmode = 0;
        for (int i = 0; i < 2; i++) build(i, 2, 4, 1'b0, 3);
        pulse_start(2, 4, 1'b0, 3);
        cyc = 0;
        while (!(vld[0] && dat[0][11:0] == 12'd1) && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("reached_beat1", 64'(dat[0][11:0]), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_valid%0d", i), 64'(vld[i]), 64'd0);
            chk($sformatf("rst_data%0d", i), 64'(dat[i]), 64'd0);
            chk($sformatf("rst_last%0d", i), 64'(lst[i]), 64'd0);
            chk($sformatf("rst_dest%0d", i), 64'(dst[i]), 64'd0);
            chk($sformatf("rst_busy%0d", i), 64'(bsy[i]), 64'd0);
            chk($sformatf("rst_sent%0d", i), 64'(sent[i]), 64'd0);
            exp_q[i].delete();
        end
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_valid", 64'(vld), 64'd0);
            chk("post_rst_busy", 64'(bsy), 64'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; num_pkts = '0; pkt_len = '0; rr_mode = 1'b0; fixed_dest = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("reset_valid%0d", i), 64'(vld[i]), 64'd0);
            chk($sformatf("reset_last%0d", i), 64'(lst[i]), 64'd0);
            chk($sformatf("reset_data%0d", i), 64'(dat[i]), 64'd0);
            chk($sformatf("reset_dest%0d", i), 64'(dst[i]), 64'd0);
            chk($sformatf("reset_busy%0d", i), 64'(bsy[i]), 64'd0);
            chk($sformatf("reset_done%0d", i), 64'(dn[i]), 64'd0);
            chk($sformatf("reset_sent%0d", i), 64'(sent[i]), 64'd0);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b1;

        do_run(3, 2, 1'b0, 1, 0, 1'b0);
        do_run(4, 1, 1'b1, 0, 0, 1'b0);
        do_run(5, 3, 1'b0, 2, 1, 1'b0);
        do_run(2, 1, 1'b0, 0, 0, 1'b0);
        do_run(0, 3, 1'b0, 1, 0, 1'b0);
        do_run(3, 0, 1'b1, 0, 1, 1'b0);
        do_run(4, 2, 1'b1, 3, 2, 1'b1);
        reset_midpacket();
        do_run(2, 2, 1'b0, 1, 0, 1'b0);

        for (int k = 0; k < 24; k++) begin
            do_run($urandom_range(0, 5), $urandom_range(0, 6), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
